// File: rtl/button_gesture_ctrl.sv
// Gesture sequencer: turns a debounced button level into SINGLE/DOUBLE/LONG events queued in a
// first-word-fall-through event FIFO. Define BUTTON_GESTURE_REPEAT_EN for periodic REPEAT events while held.
module button_gesture_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             btn_level,
    input  logic [CNT_W-1:0] long_press_cycles,
    input  logic [CNT_W-1:0] double_click_gap_cycles,
`ifdef BUTTON_GESTURE_REPEAT_EN
    input  logic [CNT_W-1:0] repeat_period_cycles,
`endif
    output logic             event_valid,
    input  logic             event_ready,
    output logic [1:0]       event_code,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic             btn_held
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] CODE_SINGLE = 2'd0;
    localparam logic [1:0] CODE_DOUBLE = 2'd1;
    localparam logic [1:0] CODE_LONG   = 2'd2;
`ifdef BUTTON_GESTURE_REPEAT_EN
    localparam logic [1:0] CODE_REPEAT = 2'd3;
`endif
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [AW:0]      LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]      LVL_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HELD
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             btn_prev;
    logic             rise, fall;
    logic             push, pop, push_ok, drop, full;
    logic [1:0]       push_code;
    logic [1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level;
    logic [1:0]       last_code;

    // Counter value on which a timed condition fires; a programmed 0 behaves like 1.
    function automatic logic [CNT_W-1:0] last_tick(input logic [CNT_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - CNT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign rise = btn_level & ~btn_prev;
    assign fall = ~btn_level & btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            btn_prev <= 1'b1;
            btn_held <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            btn_prev <= btn_level;
            btn_held <= btn_level;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        push      = 1'b0;
        push_code = CODE_SINGLE;
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = PRESS1;
                        cnt_n   = '0;
                    end
                end
                PRESS1: begin
                    if (fall) begin
                        state_n = WAIT2;
                        cnt_n   = '0;
                    end else if (cnt == last_tick(long_press_cycles)) begin
                        push      = 1'b1;
                        push_code = CODE_LONG;
                        state_n   = LONG_HELD;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
                end
                WAIT2: begin
                    // A rise on the timeout cycle still counts as the second press.
                    if (rise) begin
                        state_n = PRESS2;
                        cnt_n   = '0;
                    end else if (cnt == last_tick(double_click_gap_cycles)) begin
                        push      = 1'b1;
                        push_code = CODE_SINGLE;
                        state_n   = IDLE;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
                end
                PRESS2: begin
                    if (fall) begin
                        push      = 1'b1;
                        push_code = CODE_DOUBLE;
                        state_n   = IDLE;
                        cnt_n     = '0;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
`ifdef BUTTON_GESTURE_REPEAT_EN
                    else if (cnt == last_tick(repeat_period_cycles)) begin
                        push      = 1'b1;
                        push_code = CODE_REPEAT;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
`endif
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Event FIFO: a full queue still accepts a push when the head is popped in the same cycle.
    assign full        = (level == LVL_FULL);
    assign event_valid = (level != '0);
    assign pop         = event_valid & event_ready;
    assign push_ok     = push & (~full | pop);
    assign drop        = push & full & ~pop;
    assign event_code  = event_valid ? mem[rd_ptr] : last_code;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            last_code <= CODE_SINGLE;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                last_code <= mem[rd_ptr];
            end
            if (push_ok && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push_ok) begin
                level <= level - LVL_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// Bench for button_gesture_ctrl: time-stamp based gesture model with an event queue, checked every cycle,
// plus directed scenarios with hand-computed latencies and codes.
module tb_button_gesture_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          reset, enable, btn_level, event_ready, overflow_clr;
    logic [CW-1:0] long_cyc, gap_cyc;
    logic [CW-1:0] rep_cyc;
    logic          event_valid, overflow, btn_held;
    logic [1:0]    event_code;

    always #5 clk = ~clk;

    button_gesture_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .btn_level               (btn_level),
        .long_press_cycles       (long_cyc),
        .double_click_gap_cycles (gap_cyc),
`ifdef BUTTON_GESTURE_REPEAT_EN
        .repeat_period_cycles    (rep_cyc),
`endif
        .event_valid             (event_valid),
        .event_ready             (event_ready),
        .event_code              (event_code),
        .overflow                (overflow),
        .overflow_clr            (overflow_clr),
        .btn_held                (btn_held)
    );

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Reference model: gestures are timed as elapsed cycles since the edge that entered each phase.
    int  m_phase = 0;   // 0 none, 1 first press, 2 released gap, 3 second press, 4 long hold
    int  m_t0    = 0;
    int  m_n     = 0;
    int  m_q[$];
    int  m_last  = 0;
    bit  m_prev  = 1'b1;
    bit  m_ovf   = 1'b0;
    bit  m_held  = 1'b0;

    function automatic int eff(input logic [CW-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    always @(posedge clk) begin
        bit r, f, push, dropped;
        int code;
        m_n++;
        if (reset) begin
            m_phase = 0;
            m_q.delete();
            m_last  = 0;
            m_prev  = 1'b1;
            m_ovf   = 1'b0;
            m_held  = 1'b0;
        end else begin
            r = btn_level && !m_prev;
            f = !btn_level && m_prev;
            push = 1'b0;
            code = 0;
            if (!enable) m_phase = 0;
            else begin
                case (m_phase)
                    1: if (f) begin m_phase = 2; m_t0 = m_n; end
                       else if (m_n - m_t0 == eff(long_cyc)) begin
                           push = 1'b1; code = 2; m_phase = 4; m_t0 = m_n;
                       end
                    2: if (r) m_phase = 3;
                       else if (m_n - m_t0 == eff(gap_cyc)) begin push = 1'b1; code = 0; m_phase = 0; end
                    3: if (f) begin push = 1'b1; code = 1; m_phase = 0; end
                    4: begin
                        if (f) m_phase = 0;
`ifdef BUTTON_GESTURE_REPEAT_EN
                        else if (m_n - m_t0 == eff(rep_cyc)) begin push = 1'b1; code = 3; m_t0 = m_n; end
`endif
                    end
                    default: if (r) begin m_phase = 1; m_t0 = m_n; end
                endcase
            end
            if (m_q.size() > 0 && event_ready) m_last = m_q.pop_front();
            dropped = 1'b0;
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(code);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            m_prev = btn_level;
            m_held = btn_level;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(event_valid), 32'(m_q.size() > 0));
            check("code", 32'(event_code), 32'((m_q.size() > 0) ? m_q[0] : m_last));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("btn_held", 32'(btn_held), 32'(m_held));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Counts negedges until event_valid, bounded.
    task automatic wait_valid(input string name, input int exp_ticks);
        int k = 0;
        while (!event_valid && k < 400) begin
            tick();
            k++;
        end
        check(name, 32'(k), 32'(exp_ticks));
    endtask

    task automatic click(input int hold, input int after);
        btn_level = 1'b1;
        tick(hold);
        btn_level = 1'b0;
        tick(after);
    endtask

    int lv[5] = '{0, 1, 3, 9, 25};

    initial begin
        reset = 1'b1; enable = 1'b1; btn_level = 1'b0; event_ready = 1'b1; overflow_clr = 1'b0;
        long_cyc = 100; gap_cyc = 20; rep_cyc = 25;
        tick(3);
        check("reset_valid", 32'(event_valid), 0);
        check("reset_code", 32'(event_code), 0);
        check("reset_ovf", 32'(overflow), 0);
        check("reset_held", 32'(btn_held), 0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick(3);

        // Single click: fall sampled at F0, SINGLE pushed at F20, seen on the 21st negedge.
        btn_level = 1'b1; tick(10); btn_level = 1'b0;
        wait_valid("single_latency", 21);
        check("single_code", 32'(event_code), 0);
        tick(15);
        check("single_drained", 32'(event_valid), 0);

        // Double click: DOUBLE pushed on the edge sampling the second fall.
        click(10, 5);
        btn_level = 1'b1; tick(10);
        check("double_none_yet", 32'(event_valid), 0);
        btn_level = 1'b0;
        wait_valid("double_latency", 1);
        check("double_code", 32'(event_code), 1);
        tick(30);
        check("double_no_single", 32'(event_valid), 0);

        // Long press: LONG pushed 100 edges after the rise.
        btn_level = 1'b1;
        wait_valid("long_latency", 101);
        check("long_code", 32'(event_code), 2);
        tick(49);
        btn_level = 1'b0;
        tick(30);
        check("long_release_quiet", 32'(event_valid), 0);

        // Overflow: five SINGLEs with the consumer stalled.
        event_ready = 1'b0;
        repeat (5) click(3, 25);
        check("ovf_set", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(event_valid), 1);
            check("drain_code", 32'(event_code), 0);
            event_ready = 1'b1; tick(); event_ready = 1'b0;
        end
        check("drain_empty", 32'(event_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0; tick();
        check("ovf_cleared", 32'(overflow), 0);

        // Button held through reset release.
        btn_level = 1'b1; reset = 1'b1; tick(3); reset = 1'b0;
        tick(150);
        check("held_reset_quiet", 32'(event_valid), 0);
        btn_level = 1'b0; tick(5);
        click(10, 25);
        check("repress_single", 32'(event_valid), 1);
        check("repress_code", 32'(event_code), 0);
        event_ready = 1'b1; tick(); event_ready = 1'b0;
        check("repress_only_one", 32'(event_valid), 0);

        // Enable dropped during the second press, re-enabled while held.
        click(10, 5);
        btn_level = 1'b1; tick(5);
        enable = 1'b0; tick(3); enable = 1'b1;
        tick(150);
        btn_level = 1'b0; tick(30);
        check("enable_discard", 32'(event_valid), 0);
        event_ready = 1'b1; tick(2);

        // Randomised segments; timing only changes while the FSM is forced idle.
        for (int seg = 0; seg < 8; seg++) begin
            enable = 1'b0;
            long_cyc = lv[$urandom_range(0, 4)];
            gap_cyc  = lv[$urandom_range(0, 4)];
            rep_cyc  = lv[$urandom_range(1, 4)];
            tick();
            enable = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) btn_level = ~btn_level;
                event_ready  = ($urandom_range(0, 3) != 0);
                overflow_clr = ($urandom_range(0, 30) == 0);
                enable       = ($urandom_range(0, 150) != 0);
                reset        = ($urandom_range(0, 500) == 0);
                tick();
            end
            reset = 1'b0; overflow_clr = 1'b0; enable = 1'b1;
        end

        tick(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/button_gesture_ctrl.md
Name: button_gesture_ctrl

Overview:
- Sequences the debounced level from the debounce stage into discrete user gestures: single click, double click, long press.
- Gestures are queued in a small event FIFO with a valid/ready handshake toward the register or interrupt layer.
- Sits directly after the per-button debouncer; one instance per button.

Parameters:
FIFO_DEPTH, 4, event queue entries; power of two, 2..16
CNT_W, 32, width of the timing counter and the timing inputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = gesture detection active; 0 = FSM held in IDLE, FIFO still drains
btn_level  in  1  debounced button level, 1 = pressed
long_press_cycles  in  CNT_W  hold duration (cycles) that qualifies as a long press
double_click_gap_cycles  in  CNT_W  max released gap (cycles) before a second press
event_valid  out  1  FIFO head valid
event_ready  in  1  consumer accepts head
event_code  out  2  0=SINGLE 1=DOUBLE 2=LONG 3=REPEAT (REPEAT only with macro)
overflow  out  1  sticky: event dropped because FIFO full
overflow_clr  in  1  clears overflow
btn_held  out  1  registered copy of btn_level

Behaviour:
- Reset: state=IDLE, counter=0, FIFO empty, event_valid=0, event_code=0, overflow=0, btn_held=0, btn_prev=1.
- btn_prev resets to 1: a button held through reset yields no gesture until released and pressed again.
- rise = btn_level & ~btn_prev; fall = ~btn_level & btn_prev; btn_prev updates every cycle.
- Timing inputs of 0 are treated as 1. Inputs are sampled live and must be static while not in IDLE.
- Counter saturates at all-ones and never wraps.
- FSM:
  - IDLE: on rise → PRESS1, counter=0.
  - PRESS1: counter++ while held.
    - counter==long_press_cycles-1 and still held → push LONG, go LONG_HELD.
    - fall before that → WAIT2, counter=0.
  - WAIT2: rise → PRESS2. If counter==double_click_gap_cycles-1 with no rise → push SINGLE, go IDLE.
  - PRESS2: fall → push DOUBLE, go IDLE. Holding in PRESS2 never produces LONG.
  - LONG_HELD: fall → IDLE.
- Simultaneous events: a rise in the same cycle the WAIT2 timeout matches counts as the second press; no SINGLE is pushed.
- Event latency: the event is pushed on the clock edge that samples the triggering condition. event_valid=1 from the following cycle (first-word fall-through).
- FIFO:
  - Pop when event_valid & event_ready.
  - Full with push and pop in the same cycle: both succeed, count unchanged.
  - Full with push and no pop: event dropped, overflow set the next cycle.
  - overflow_clr and a same-cycle drop: set wins.
  - Empty: event_valid=0; event_code holds its last value.
- enable=0: FSM forced to IDLE and the counter cleared next cycle; a gesture in progress is discarded with no event. FIFO contents kept. Re-enabling while the button is held produces no event until the next rise.
- Reset mid-gesture or mid-handshake: all state returns to reset values; queued events are lost.

Optional Feature:
- Macro: BUTTON_GESTURE_REPEAT_EN.
- Defined:
  - Adds input repeat_period_cycles [CNT_W].
  - In LONG_HELD, the counter restarts at 0 on entry and pushes REPEAT (code 3) each time it reaches repeat_period_cycles-1, then reloads to 0.
  - A repeat_period_cycles value of 0 is treated as 1.
- Not defined: port absent; LONG_HELD only waits for fall; code 3 is never produced.

Test Plan:
- long=100, gap=20; press for 10 cycles, release, wait 30 → exactly one SINGLE, event_valid rising 20 cycles after release, ready=1.
- Press 10, release 5, press 10, release → one DOUBLE, one cycle after the second fall; no SINGLE.
- Press and hold 150 cycles → LONG at cycle 100 after the rise; nothing on release. With macro and repeat=25: REPEAT at 125 and 150.
- ready=0, FIFO_DEPTH=4, generate 5 SINGLEs → 4 queued, overflow=1. Then a ready=1 drain shows the order SINGLE×4. Then overflow_clr → overflow=0.
- btn_level=1 through reset release, then release and re-press for 10 cycles → only one SINGLE, from the re-press.
- enable dropped during PRESS2 → no event; re-enable while held → no event until the next rise.
